// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state, opcode and control-code constants for the multicycle controller.
// The JUMP state exists only when MCC_JUMP_EN is defined.
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC     = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
`ifdef MCC_JUMP_EN
    JUMP     = 4'd11,
`endif
    ILLEGAL  = 4'd12
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;
  localparam logic [1:0] PCS_ALU   = 2'b00;
  localparam logic [1:0] PCS_OUT   = 2'b01;
  localparam logic [1:0] PCS_JUMP  = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;
  function automatic state_t decode_next(input logic [5:0] op);
    return op == OP_R ? EXEC :
           (op == OP_LW || op == OP_SW) ? MEMADR :
           op == OP_BEQ ? BRANCH :
           op == OP_ADDI ? ADDIEXEC :
`ifdef MCC_JUMP_EN
           op == OP_J ? JUMP :
`endif
           ILLEGAL;
  endfunction
endpackage

// File: rtl/mcc_output_decode.sv
// mcc_output_decode: Moore control decode from state; fetch writes gated by mem_ready.
// JUMP outputs are present only when MCC_JUMP_EN is defined.
module mcc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: ctrl.alu_src_b = SRCB_BOFF;
      MEMADR, ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      RTYPEWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_OUT;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
`ifdef MCC_JUMP_EN
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
`endif
      ILLEGAL: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with memory-ready stalls.
// Define MCC_JUMP_EN to decode opcode 000010 as a jump; otherwise it is illegal.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       Illegal,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State
);
  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= FETCH;
    else
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE:   state <= decode_next(Opcode);
        MEMADR:   state <= Opcode == OP_SW ? MEMWR : MEMRD;
        MEMRD:    if (mem_ready) state <= MEMWB;
        MEMWR:    if (mem_ready) state <= FETCH;
        EXEC:     state <= RTYPEWB;
        ADDIEXEC: state <= ADDIWB;
        default:  state <= FETCH;
      endcase
  mcc_output_decode u_dec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );
  // Reset kills every control output combinationally, so an aborted access stops at once.
  assign ctrl = reset ? dec : '0;
  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
          RegWrite, RegDst, Illegal, PCSource, ALUOp, ALUSrcB} = ctrl;
  assign State = state;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  shared memory has completed the current access this cycle.
REQ-005 SHALL have ports (output, width 1 each): PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, Illegal.
REQ-006 SHALL have ports (output, width 2 each): PCSource, ALUOp, ALUSrcB.
REQ-007 SHALL have port: State  output  4  current state encoding, for debug.

Function
REQ-008 SHALL implement a Moore FSM with states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, ILLEGAL=12.
REQ-009 SHALL treat encodings 13-15 as unreachable and transition from them to FETCH on the next edge.
REQ-010 SHALL decode opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-011 SHALL make DECODE transitions: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEXEC, j->JUMP, any other->ILLEGAL.
REQ-012 SHALL make MEMADR transitions: lw->MEMRD, sw->MEMWR.
REQ-013 SHALL make fixed transitions: MEMWB, RTYPEWB, BRANCH, ADDIWB, JUMP, ILLEGAL->FETCH; EXEC->RTYPEWB; ADDIEXEC->ADDIWB.
REQ-014 SHALL hold FETCH, MEMRD and MEMWR while mem_ready=0 and SHALL advance only on a cycle with mem_ready=1 (FETCH->DECODE, MEMRD->MEMWB, MEMWR->FETCH).
REQ-015 FETCH outputs SHALL be: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite SHALL equal mem_ready, so the IR and PC update exactly once per fetch.
REQ-016 DECODE outputs SHALL be: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-017 MEMADR and ADDIEXEC outputs SHALL be: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-018 MEMRD outputs SHALL be: MemRead=1, IorD=1; MEMWR outputs SHALL be: MemWrite=1, IorD=1; both SHALL hold these outputs stable for every stall cycle.
REQ-019 MEMWB outputs SHALL be: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-020 EXEC outputs SHALL be: ALUSrcA=1, ALUSrcB=00, ALUOp=10; RTYPEWB outputs SHALL be: RegWrite=1, RegDst=1, MemtoReg=0.
REQ-021 BRANCH outputs SHALL be: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-022 ADDIWB outputs SHALL be: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-023 JUMP outputs SHALL be: PCWrite=1, PCSource=10.
REQ-024 ILLEGAL SHALL assert Illegal=1 for exactly one cycle and no write enables.
REQ-025 Every output not listed for a state SHALL be 0 in that state.
REQ-026 Write enables (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) SHALL never be asserted in two consecutive states of one instruction, except PCWrite/IRWrite held by the mem_ready gating.

Reset
REQ-027 While reset=0, State SHALL be FETCH (0) and all control outputs SHALL be forced to 0, including MemRead, IRWrite and PCWrite.
REQ-028 Reset asserted mid-instruction SHALL abort it immediately, with no further write enable.
REQ-029 After reset deasserts, the first active cycle SHALL be FETCH.

Configuration
REQ-030 With macro MCC_JUMP_EN defined, opcode 000010 SHALL decode to JUMP.
REQ-031 Without MCC_JUMP_EN, JUMP SHALL NOT exist, opcode 000010 SHALL go to ILLEGAL, and encoding 11 SHALL be unreachable per REQ-009.

Structure
REQ-032 A shared package SHALL hold the state encoding constants, the opcode constants and the ALUOp/ALUSrcB/PCSource code constants.
REQ-033 The output decode MAY be a sub-module named mcc_output_decode (State and mem_ready in, control signals out); the state register and next-state logic SHALL stay in multicycle_control.

Verification
REQ-034 R-type: mem_ready=1, Opcode=000000 -> States 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
REQ-035 lw with fetch stall: mem_ready=0 for 3 cycles, then 1, Opcode=100011 -> FETCH held 4 cycles with IRWrite=1 only on the 4th; then States 1,2,3,4,0.
REQ-036 sw with a 2-cycle data stall -> MEMWR held 3 cycles with MemWrite=1 and IorD=1 throughout; then FETCH.
REQ-037 beq -> States 0,1,8,0 with PCWriteCond=1 and PCSource=01 in state 8; Opcode=111111 -> States 0,1,12,0 with Illegal=1 for one cycle.
REQ-038 Reset pulsed low during MEMWR -> all outputs 0 within the same cycle; State=0; no MemWrite after release until a new sw instruction.
REQ-039 Opcode=000010 with MCC_JUMP_EN -> state 11 with PCWrite=1 and PCSource=10; without MCC_JUMP_EN -> state 12 with Illegal=1.
